// File: rtl/ifetch.sv
// ifetch: halfword instruction fetch queue with a single-outstanding word fetch port.
// Holds up to four {ins, pc} halfwords; redirects flush the queue and drop one in-flight response.
module ifetch #(
    parameter int RV = 32,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ireq,
    output logic [RV-1:0] iaddr,
    input  logic          iack,
    input  logic [31:0]   idata,
    input  logic          ierr,
    input  logic          ins_ready,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          idone,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc
);
    logic [15:0]   ins_q [4];
    logic [RV-1:0] pc_q  [4];
    logic [1:0]    head;
    logic [2:0]    count;
    logic [RV-1:0] fetch_pc;
    logic          discard;
    logic          accept, fill, busy, issue;
    logic [2:0]    n, cnt_nxt;
    logic [RV-1:0] fpc_word, fpc_nxt;
    logic [15:0]   lo, hi;
    logic [1:0]    tail;

    assign ins    = ins_q[head];
    assign ins_pc = pc_q[head];
    assign idone  = (count != 3'd0) & ins_ready & !redirect;

    always_comb begin
        accept   = ireq & iack;
        fill     = accept & !discard & !redirect;
        busy     = ireq & !iack;
        fpc_word = fetch_pc & ~RV'(3);
        n        = fill ? (fetch_pc[1] ? 3'd1 : 3'd2) : 3'd0;
        cnt_nxt  = redirect ? 3'd0 : count + n - {2'b00, idone};
        fpc_nxt  = redirect ? (redirect_pc & ~RV'(1))
                 : (accept & !discard) ? fpc_word + RV'(4) : fetch_pc;
        // The room check uses post-edge occupancy so a refill can never overrun the queue.
        issue    = !busy & !redirect & (cnt_nxt <= 3'd2);
        lo       = ierr ? 16'h0000 : idata[15:0];
        hi       = ierr ? 16'h0000 : idata[31:16];
        tail     = head + count[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ireq     <= 1'b0;
            iaddr    <= '0;
            count    <= 3'd0;
            head     <= 2'd0;
            discard  <= 1'b0;
            fetch_pc <= RESET_PC & ~RV'(1);
        end else begin
            ireq     <= busy | issue;
            iaddr    <= issue ? (fpc_nxt & ~RV'(3)) : iaddr;
            count    <= cnt_nxt;
            head     <= head + {1'b0, idone};
            fetch_pc <= fpc_nxt;
            discard  <= redirect ? busy : discard & !accept;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && fetch_pc[1]) begin
            ins_q[tail] <= hi;
            pc_q[tail]  <= fpc_word + RV'(2);
        end else if (fill) begin
            ins_q[tail]         <= lo;
            pc_q[tail]          <= fpc_word;
            ins_q[tail + 2'd1]  <= hi;
            pc_q[tail + 2'd1]   <= fpc_word + RV'(2);
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scenarios plus a randomized run against a halfword-stream queue model.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset, ireq, iack, ierr, ins_ready, idone, redirect;
    logic [31:0] iaddr, idata, ins_pc, redirect_pc;
    logic [15:0] ins;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch #(.RV(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr), .iack(iack),
        .idata(idata), .ierr(ierr), .ins_ready(ins_ready), .ins(ins),
        .ins_pc(ins_pc), .idone(idone), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, a[15:0] + 16'h1357};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:2] == 5'd13;
    endfunction

    function automatic logic [15:0] ref_ins(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc & ~32'd3);
        return mem_err(pc & ~32'd3) ? 16'h0000 : (pc[1] ? w[31:16] : w[15:0]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input logic [31:0] target);
        redirect = 1'b1; redirect_pc = target; iack = ireq; idata = 32'h0; ierr = 1'b0; ins_ready = 1'b0;
        tick;
        redirect = 1'b0; iack = 1'b0;
    endtask

    task automatic first_fetch(input string name);
        int n = 0;
        while (ireq !== 1'b1 && n < 4) begin tick; n++; end
        checks++; if (n < 1 || n > 2) begin errors++; $display("FAIL %s_latency got %0d want 1..2", name, n); end
        checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL %s_iaddr got %h want 00000100", name, iaddr); end
    endtask

    task automatic test_reset;
        reset = 1'b0; iack = 1'b0; idata = '0; ierr = 1'b0; ins_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL reset_ireq got %b want 0", ireq); end
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL reset_idone got %b want 0", idone); end
        reset = 1'b1;
        first_fetch("reset_first");
    endtask

    task automatic test_basic;
        iack = 1'b1; idata = 32'h4A014581; ins_ready = 1'b1;
        #1;
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL basic_empty got %b want 0", idone); end
        tick; iack = 1'b0; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'h4581, 32'h100}) begin errors++; $display("FAIL basic_lo got %b %h %h want 1 4581 00000100", idone, ins, ins_pc); end
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL basic_next got %b %h want 1 00000104", ireq, iaddr); end
        tick; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'h4A01, 32'h102}) begin errors++; $display("FAIL basic_hi got %b %h %h want 1 4a01 00000102", idone, ins, ins_pc); end
        tick; #1;
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", idone); end
    endtask

    task automatic test_unaligned;
        redirect = 1'b1; redirect_pc = 32'h206; iack = 1'b1; idata = 32'h11112222;
        #1;
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL unal_redir_idone got %b want 0", idone); end
        tick; redirect = 1'b0; iack = 1'b0; #1;
        checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL unal_gap got %b want 0", ireq); end
        tick; #1;
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h204}) begin errors++; $display("FAIL unal_iaddr got %b %h want 1 00000204", ireq, iaddr); end
        iack = 1'b1; idata = 32'hBEEFCAFE;
        tick; iack = 1'b0; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'hBEEF, 32'h206}) begin errors++; $display("FAIL unal_ins got %b %h %h want 1 beef 00000206", idone, ins, ins_pc); end
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h208}) begin errors++; $display("FAIL unal_next got %b %h want 1 00000208", ireq, iaddr); end
        tick; #1;
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL unal_single got %b want 0", idone); end
    endtask

    task automatic test_full;
        int acks = 0;
        logic [3:0] exp_req = 4'b1100;
        flush(32'h400);
        for (int i = 0; i < 8; i++) begin
            tick;
            iack = ireq; idata = mem_word(iaddr);
            #1;
            acks += int'(iack);
        end
        iack = 1'b0;
        checks++; if (acks != 2) begin errors++; $display("FAIL full_acks got %0d want 2", acks); end
        checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", ireq); end
        ins_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({idone, ins_pc, ins} !== {1'b1, 32'h400 + 32'(2 * k), ref_ins(32'h400 + 32'(2 * k))}) begin
                errors++; $display("FAIL full_pop%0d got %b %h %h want 1 %h %h", k, idone, ins_pc, ins, 32'h400 + 32'(2 * k), ref_ins(32'h400 + 32'(2 * k)));
            end
            checks++; if (ireq !== exp_req[k]) begin errors++; $display("FAIL full_refetch%0d got %b want %b", k, ireq, exp_req[k]); end
            if (k == 2) begin checks++; if (iaddr !== 32'h408) begin errors++; $display("FAIL full_refetch_addr got %h want 00000408", iaddr); end end
            tick;
        end
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", idone); end
    endtask

    task automatic test_redirect_pending;
        flush(32'h104);
        ins_ready = 1'b1;
        tick;
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL pend_issue got %b %h want 1 00000104", ireq, iaddr); end
        redirect = 1'b1; redirect_pc = 32'h300;
        tick; redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({ireq, iaddr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL pend_hold%0d got %b %h want 1 00000104", i, ireq, iaddr); end
            tick;
        end
        iack = 1'b1; idata = 32'hDEAD1111;
        #1;
        checks++; if ({idone, ireq, iaddr} !== {1'b0, 1'b1, 32'h104}) begin errors++; $display("FAIL pend_ack got %b %b %h want 0 1 00000104", idone, ireq, iaddr); end
        tick; iack = 1'b0; #1;
        checks++; if ({idone, ireq, iaddr} !== {1'b0, 1'b1, 32'h300}) begin errors++; $display("FAIL pend_new got %b %b %h want 0 1 00000300", idone, ireq, iaddr); end
        iack = 1'b1; idata = 32'h22223333;
        tick; iack = 1'b0; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'h3333, 32'h300}) begin errors++; $display("FAIL pend_data got %b %h %h want 1 3333 00000300", idone, ins, ins_pc); end
    endtask

    task automatic test_ierr;
        flush(32'h108);
        ins_ready = 1'b1;
        tick;
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h108}) begin errors++; $display("FAIL ierr_issue got %b %h want 1 00000108", ireq, iaddr); end
        iack = 1'b1; ierr = 1'b1; idata = 32'hFFFFFFFF;
        tick; iack = 1'b0; ierr = 1'b0; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'h0000, 32'h108}) begin errors++; $display("FAIL ierr_lo got %b %h %h want 1 0000 00000108", idone, ins, ins_pc); end
        tick; #1;
        checks++; if ({idone, ins, ins_pc} !== {1'b1, 16'h0000, 32'h10A}) begin errors++; $display("FAIL ierr_hi got %b %h %h want 1 0000 0000010a", idone, ins, ins_pc); end
    endtask

    task automatic test_same_cycle;
        flush(32'h500);
        tick;
        iack = 1'b1; idata = 32'h55556666;
        tick;
        iack = 1'b1; idata = 32'h77778888; redirect = 1'b1; redirect_pc = 32'h600; ins_ready = 1'b1;
        #1;
        checks++; if (idone !== 1'b0) begin errors++; $display("FAIL same_idone got %b want 0", idone); end
        tick; redirect = 1'b0; iack = 1'b0; #1;
        checks++; if ({idone, ireq} !== 2'b00) begin errors++; $display("FAIL same_flush got %b %b want 0 0", idone, ireq); end
        tick; #1;
        checks++; if ({ireq, iaddr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL same_next got %b %h want 1 00000600", ireq, iaddr); end
    endtask

    task automatic test_async_reset;
        reset = 1'b0;
        #1;
        checks++; if ({ireq, idone} !== 2'b00) begin errors++; $display("FAIL areset got %b %b want 0 0", ireq, idone); end
        tick;
        reset = 1'b1;
        first_fetch("areset_first");
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] sfetch, req_addr, rp;
        logic held, exp_ireq, tainted, exp_idone;
        int wait_n, delivered;
        flush(32'h1000);
        sfetch = 32'h1000; req_addr = '0; held = 1'b0; exp_ireq = 1'b0; tainted = 1'b0; wait_n = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            checks++; if (ireq !== exp_ireq) begin errors++; $display("FAIL rnd_ireq c%0d got %b want %b", c, ireq, exp_ireq); end
            if (ireq && !held) begin
                checks++; if (iaddr !== (sfetch & ~32'd3)) begin errors++; $display("FAIL rnd_iaddr c%0d got %h want %h", c, iaddr, sfetch & ~32'd3); end
                req_addr = iaddr; wait_n = $urandom_range(0, 3); tainted = 1'b0;
            end else if (ireq) begin
                checks++; if (iaddr !== req_addr) begin errors++; $display("FAIL rnd_hold c%0d got %h want %h", c, iaddr, req_addr); end
            end
            iack = ireq && wait_n == 0; idata = mem_word(iaddr); ierr = mem_err(iaddr);
            ins_ready = $urandom_range(0, 3) != 0; redirect = $urandom_range(0, 19) == 0;
            rp = 32'h1000 + 32'($urandom_range(0, 511)); redirect_pc = rp;
            #1;
            exp_idone = q.size() != 0 && ins_ready && !redirect;
            checks++; if (idone !== exp_idone) begin errors++; $display("FAIL rnd_idone c%0d got %b want %b", c, idone, exp_idone); end
            if (exp_idone) begin
                checks++;
                if (ins_pc !== q[0] || ins !== ref_ins(q[0])) begin errors++; $display("FAIL rnd_ins c%0d got %h@%h want %h@%h", c, ins, ins_pc, ref_ins(q[0]), q[0]); end
                void'(q.pop_front()); delivered++;
            end
            if (iack && !tainted && !redirect) begin
                if (!sfetch[1]) q.push_back(req_addr);
                q.push_back(req_addr + 32'd2);
                sfetch = req_addr + 32'd4;
            end
            if (redirect) begin
                q.delete(); sfetch = rp & ~32'd1;
                if (ireq && !iack) tainted = 1'b1;
            end
            if (ireq && !iack && wait_n > 0) wait_n--;
            held = ireq && !iack;
            exp_ireq = held || (!redirect && q.size() <= 2);
            checks++; if (q.size() > 4) begin errors++; $display("FAIL rnd_depth c%0d got %0d want <=4", c, q.size()); end
            tick;
        end
        iack = 1'b0; redirect = 1'b0;
        checks++; if (delivered < 300) begin errors++; $display("FAIL rnd_progress got %0d want >=300", delivered); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_unaligned;
        test_full;
        test_redirect_pending;
        test_ierr;
        test_same_cycle;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
